// File: rtl/stoplight_pkg.sv
// stoplight_pkg: shared light-slice and phase encodings for the stoplight controller
package stoplight_pkg;
  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] GRN = 3'b100;
  localparam logic [1:0] PH_GREEN = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALL_RED = 2'd2;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational pick of the first requester strictly after cur, wrapping circularly
module rr_select #(
  parameter int N_APPROACH = 2
) (
  input  logic [N_APPROACH-1:0]         req,
  input  logic [$clog2(N_APPROACH)-1:0] cur,
  output logic [$clog2(N_APPROACH)-1:0] nxt,
  output logic                          valid
);
  localparam int W = $clog2(N_APPROACH);
  always_comb begin
    nxt = cur;
    valid = 1'b0;
    for (int k = N_APPROACH - 1; k >= 1; k--) begin
      if (req[(int'(cur) + k) % N_APPROACH]) begin
        nxt = W'((int'(cur) + k) % N_APPROACH);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stoplight_rr.sv
// stoplight_rr: round-robin traffic light controller with green/yellow/all-red phases
module stoplight_rr
  import stoplight_pkg::*;
#(
  parameter int N_APPROACH = 2,
  parameter int MIN_GREEN = 4,
  parameter int YELLOW = 1,
  parameter int ALL_RED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_APPROACH-1:0]         car_present,
  output logic [3*N_APPROACH-1:0]       lights,
  output logic [$clog2(N_APPROACH)-1:0] green_idx,
  output logic [1:0]                    phase
);
  localparam int W = $clog2(N_APPROACH);
  localparam int MG_Y = MIN_GREEN > YELLOW ? MIN_GREEN : YELLOW;
  localparam int TMAX = MG_Y > ALL_RED ? MG_Y : ALL_RED;
  localparam int TW = $clog2(TMAX + 1);
  localparam int AR_LAST = ALL_RED > 0 ? ALL_RED - 1 : 0;
  localparam logic [N_APPROACH-1:0] ONE = {{(N_APPROACH-1){1'b0}}, 1'b1};
  logic [W-1:0] next_idx, sel;
  logic sel_valid, go_yellow, yellow_done, enter_green;
  logic [TW-1:0] timer;
  logic [1:0] next_phase;
  logic [N_APPROACH-1:0] req_q, others, green_mask, next_mask;
  assign green_mask = ONE << green_idx;
  assign next_mask = ONE << next_idx;
  assign others = (req_q | car_present) & ~green_mask;
  rr_select #(.N_APPROACH(N_APPROACH)) u_rr (
    .req(others),
    .cur(green_idx),
    .nxt(sel),
    .valid(sel_valid)
  );
  assign go_yellow = phase == PH_GREEN && timer >= TW'(MIN_GREEN - 1) && sel_valid;
  assign yellow_done = phase == PH_YELLOW && timer == TW'(YELLOW - 1);
  assign enter_green = (yellow_done && ALL_RED == 0) || (phase == PH_ALL_RED && timer == TW'(AR_LAST));
  assign next_phase = go_yellow ? PH_YELLOW : enter_green ? PH_GREEN : yellow_done ? PH_ALL_RED : phase;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_GREEN;
      green_idx <= '0;
      next_idx <= '0;
      timer <= '0;
      req_q <= '0;
    end else begin
      phase <= next_phase;
      timer <= next_phase != phase ? '0 : &timer ? timer : timer + TW'(1);
      if (go_yellow) next_idx <= sel;
      if (enter_green) green_idx <= next_idx;
      req_q <= (req_q | (car_present & ~(phase == PH_GREEN ? green_mask : '0))) & ~(enter_green ? next_mask : '0);
    end
  end
  always_comb begin
    lights = '0;
    for (int i = 0; i < N_APPROACH; i++)
      lights[3*i +: 3] = W'(i) != green_idx ? RED : phase == PH_GREEN ? GRN : phase == PH_YELLOW ? YLW : RED;
  end
endmodule

// File: tb/tb_stoplight_rr.sv
// tb_stoplight_rr: randomized and directed checks of stoplight_rr against a cycle model
module tb_stoplight_rr;
  localparam int MG = 4;
  localparam int YL = 2;
  localparam int AR = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] car = '0;
  logic [11:0] lights;
  logic [1:0] gidx, phase;
  logic [1:0] car_b = '0;
  logic [5:0] lights_b;
  logic gidx_b;
  logic [1:0] phase_b;
  int errors = 0;
  int checks = 0;
  int m_ph, m_g, m_n, m_age, m_left;
  logic [3:0] m_req;
  always #5 clk = ~clk;
  stoplight_rr #(.N_APPROACH(4), .MIN_GREEN(MG), .YELLOW(YL), .ALL_RED(AR)) dut (
    .clk(clk), .rst(rst), .car_present(car), .lights(lights), .green_idx(gidx), .phase(phase)
  );
  stoplight_rr #(.N_APPROACH(2), .MIN_GREEN(4), .YELLOW(2), .ALL_RED(0)) dut_b (
    .clk(clk), .rst(rst), .car_present(car_b), .lights(lights_b), .green_idx(gidx_b), .phase(phase_b)
  );
  function automatic int first_after(input logic [3:0] p, input int g);
    for (int k = 1; k < 4; k++)
      if (p[(g + k) % 4]) return (g + k) % 4;
    return g;
  endfunction
  function automatic logic [11:0] exp_lights();
    logic [11:0] l;
    for (int i = 0; i < 4; i++)
      l[3*i +: 3] = (m_ph == 2 || i != m_g) ? 3'b001 : (m_ph == 0 ? 3'b100 : 3'b010);
    return l;
  endfunction
  function automatic bit excl_ok(input logic [11:0] l, input int n);
    int nr;
    logic [2:0] s;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      s = l[3*i +: 3];
      if (s != 3'b001 && s != 3'b010 && s != 3'b100) return 1'b0;
      if (s != 3'b001) nr++;
    end
    return nr <= 1;
  endfunction
  task automatic enter_green();
    m_g = m_n;
    m_req[m_g] = 1'b0;
    m_ph = 0;
    m_age = 0;
  endtask
  task automatic model_step(input logic [3:0] c, input logic r);
    logic [3:0] pend;
    if (r) begin
      m_ph = 0; m_g = 0; m_n = 0; m_age = 0; m_left = 0; m_req = '0;
      return;
    end
    if (m_ph == 0) begin
      pend = m_req | c;
      pend[m_g] = 1'b0;
      m_req = pend;
      if (m_age >= MG - 1 && pend != 0) begin
        m_n = first_after(pend, m_g);
        m_ph = 1;
        m_left = YL;
      end else m_age++;
    end else begin
      m_req = m_req | c;
      m_left--;
      if (m_left == 0) begin
        if (m_ph == 1 && AR > 0) begin
          m_ph = 2;
          m_left = AR;
        end else enter_green();
      end
    end
  endtask
  task automatic tick(input logic [3:0] ca, input logic [1:0] cb);
    car = ca;
    car_b = cb;
    model_step(ca, rst);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick('0, '0);
    tick('0, '0);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (dut.req_q !== 4'b0000) begin errors++; $display("FAIL reset_req got=%b exp=0000", dut.req_q); end
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (lights !== 12'b001_001_001_100 || phase !== 2'd0 || gidx !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d lights=%b phase=%0d gidx=%0d exp lights=001001001100 phase=0 gidx=0", c, lights, phase, gidx);
      end
      tick('0, '0);
    end
  endtask
  task automatic test_single();
    logic [11:0] el;
    int ep, eg;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      ep = c < 4 ? 0 : c < 6 ? 1 : c == 6 ? 2 : 0;
      eg = c < 7 ? 0 : 2;
      el = c < 4 ? 12'b001_001_001_100 : c < 6 ? 12'b001_001_001_010 : c == 6 ? 12'b001_001_001_001 : 12'b001_100_001_001;
      checks++;
      if (lights !== el || phase !== 2'(ep) || gidx !== 2'(eg)) begin
        errors++;
        $display("FAIL single cyc=%0d lights=%b phase=%0d gidx=%0d exp lights=%b phase=%0d gidx=%0d", c, lights, phase, gidx, el, ep, eg);
      end
      tick(c == 1 ? 4'b0100 : 4'b0000, '0);
    end
  endtask
  task automatic test_rr_wrap();
    int order[$];
    int glen, prev;
    bit found, held;
    do_reset();
    tick(4'b0100, '0);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (phase == 2'd0 && gidx == 2'd2) found = 1'b1;
      else tick('0, '0);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rr_reach2 got gidx=%0d phase=%0d exp gidx=2 phase=0", gidx, phase); end
    held = 1'b1;
    glen = 1;
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if ({lights, phase, gidx} !== {exp_lights(), 2'(m_ph), 2'(m_g)}) begin
        errors++;
        $display("FAIL rr_model cyc=%0d lights=%b phase=%0d gidx=%0d exp lights=%b phase=%0d gidx=%0d", c, lights, phase, gidx, exp_lights(), m_ph, m_g);
      end
      if (phase == 2'd1 && prev == 0 && gidx != 2'd2) begin
        checks++;
        if (glen < 4) begin errors++; $display("FAIL rr_min_green idx=%0d got=%0d exp>=4", gidx, glen); end
      end
      if (phase == 2'd0 && prev != 0) begin
        order.push_back(int'(gidx));
        glen = 0;
      end
      if (phase == 2'd0) glen++;
      if (held && phase == 2'd1 && gidx == 2'd3) held = 1'b0;
      prev = int'(phase);
      tick(held ? 4'b1010 : 4'b0000, '0);
    end
    checks++;
    if (order.size() != 2 || order[0] != 3 || order[1] != 1) begin
      errors++;
      $display("FAIL rr_order got size=%0d first=%0d second=%0d exp 3 then 1", order.size(), order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1);
    end
    checks++;
    if (phase !== 2'd0 || gidx !== 2'd1) begin errors++; $display("FAIL rr_rest got phase=%0d gidx=%0d exp phase=0 gidx=1", phase, gidx); end
  endtask
  task automatic test_mask();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (phase !== 2'd0 || gidx !== 2'd0 || dut.req_q !== 4'b0000) begin
        errors++;
        $display("FAIL mask cyc=%0d phase=%0d gidx=%0d req=%b exp phase=0 gidx=0 req=0000", c, phase, gidx, dut.req_q);
      end
      tick(4'b0001, '0);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 5; c++) tick(c == 0 ? 4'b1000 : c == 4 ? 4'b0010 : 4'b0000, '0);
    checks++;
    if (phase !== 2'd1 || gidx !== 2'd0 || dut.req_q !== 4'b1010) begin
      errors++;
      $display("FAIL mid_pre phase=%0d gidx=%0d req=%b exp phase=1 gidx=0 req=1010", phase, gidx, dut.req_q);
    end
    rst = 1'b1;
    tick('0, '0);
    rst = 1'b0;
    checks++;
    if (lights !== 12'b001_001_001_100 || phase !== 2'd0 || gidx !== 2'd0 || dut.req_q !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset lights=%b phase=%0d gidx=%0d req=%b exp lights=001001001100 phase=0 gidx=0 req=0000", lights, phase, gidx, dut.req_q);
    end
  endtask
  task automatic test_random();
    logic [3:0] c4;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if ({lights, phase, gidx} !== {exp_lights(), 2'(m_ph), 2'(m_g)} || dut.req_q !== m_req) begin
        errors++;
        $display("FAIL rand_model cyc=%0d lights=%b phase=%0d gidx=%0d req=%b exp lights=%b phase=%0d gidx=%0d req=%b", c, lights, phase, gidx, dut.req_q, exp_lights(), m_ph, m_g, m_req);
      end
      checks++;
      if (!excl_ok(lights, 4)) begin errors++; $display("FAIL rand_excl cyc=%0d lights=%b exp one-hot slices, at most one non-red", c, lights); end
      for (int i = 0; i < 4; i++) c4[i] = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick(c4, '0);
    end
    rst = 1'b0;
  endtask
  task automatic test_param_edge();
    logic [5:0] el;
    int ep, eg;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      ep = c < 4 ? 0 : c < 6 ? 1 : 0;
      eg = c < 6 ? 0 : 1;
      el = c < 4 ? 6'b001_100 : c < 6 ? 6'b001_010 : 6'b100_001;
      checks++;
      if (lights_b !== el || phase_b !== 2'(ep) || gidx_b !== 1'(eg)) begin
        errors++;
        $display("FAIL param_edge cyc=%0d lights=%b phase=%0d gidx=%0d exp lights=%b phase=%0d gidx=%0d", c, lights_b, phase_b, gidx_b, el, ep, eg);
      end
      checks++;
      if (!excl_ok({6'b0, lights_b}, 2)) begin errors++; $display("FAIL param_excl cyc=%0d lights=%b exp exclusive slices", c, lights_b); end
      tick('0, c == 1 ? 2'b10 : 2'b00);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_mask();
    test_reset_mid();
    test_random();
    test_param_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
